// File: rtl/mem_stage_access_if.sv
// -----------------------------------------------------------------------------
// mem_stage_access_if
//   Data-RAM request/acknowledge bus between the MEM stage and the data RAM.
//
//   Signals:
//     ram_req   - access request, held until ram_ack
//     ram_we    - 1 = write, 0 = read
//     ram_addr  - byte address (word accesses only)
//     ram_wdata - store data
//     ram_rdata - load data, valid with ram_ack
//     ram_ack   - access complete
//
//   Modports:
//     master - MEM stage side (drives the request)
//     slave  - RAM side (drives the response)
// -----------------------------------------------------------------------------
interface mem_stage_access_if;
  logic        ram_req;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        ram_ack;

  modport master (
    output ram_req, ram_we, ram_addr, ram_wdata,
    input  ram_rdata, ram_ack
  );

  modport slave (
    input  ram_req, ram_we, ram_addr, ram_wdata,
    output ram_rdata, ram_ack
  );
endinterface

// File: rtl/mem_stage_access.sv
// -----------------------------------------------------------------------------
// mem_stage_access
//   Consumer end of the EX/MEM pipeline register. Performs one load/store at a
//   time against the data RAM over a req/ack handshake, stalls the upstream
//   stages while an access is outstanding and registers the MEM/WB bundle.
//
//   Parameters:
//     TIMEOUT_CYCLES - ACCESS cycles to wait for ram_ack before bus_error (1..255)
//     RA_REG         - destination register forced for Jal writes
//
//   Ports:
//     clk, reset            - clock, asynchronous active-low reset
//     ex_mem_*              - registered EX/MEM bundle
//                             ctrl: [0] MemRead [1] MemWrite [2] RegWrite
//                                   [3] MemtoReg [4] Jal
//     ram                   - data-RAM bus (mem_stage_access_if.master)
//     stall                 - freeze IF/ID/EX and the EX/MEM register
//     bus_error             - one-cycle pulse on access timeout
//     wb_*                  - registered MEM/WB bundle
//
//   Build option:
//     MEM_STAGE_MISALIGN_TRAP_EN - when defined, a mem op whose address is not
//       word aligned issues no RAM request, pulses misalign_exc for one cycle
//       and writes back a bundle with wb_reg_write=0. When undefined the
//       misalign_exc port is absent and addresses pass to RAM unchanged.
// -----------------------------------------------------------------------------
module mem_stage_access #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [4:0]  RA_REG         = 5'd31
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ex_mem_valid,
  input  logic [4:0]              ex_mem_reg_dest,
  input  logic [31:0]             ex_mem_write_data,
  input  logic [31:0]             ex_mem_alu_result,
  input  logic [31:0]             ex_mem_instruction,
  input  logic [31:0]             ex_mem_pc,
  input  logic [4:0]              ex_mem_ctrl,
  mem_stage_access_if.master      ram,
  output logic                    stall,
  output logic                    bus_error,
  output logic                    wb_valid,
  output logic                    wb_reg_write,
  output logic [4:0]              wb_reg_dest,
  output logic [31:0]             wb_data,
  output logic [31:0]             wb_instruction
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  ,
  output logic                    misalign_exc
`endif
);

  typedef enum logic {IDLE, ACCESS} state_e;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  // Control bit decode
  logic mem_read, mem_write, reg_write, mem_to_reg, jal;
  assign mem_read   = ex_mem_ctrl[0];
  assign mem_write  = ex_mem_ctrl[1];
  assign reg_write  = ex_mem_ctrl[2];
  assign mem_to_reg = ex_mem_ctrl[3];
  assign jal        = ex_mem_ctrl[4];

  logic misaligned;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  assign misaligned = |ex_mem_alu_result[1:0];
`else
  assign misaligned = 1'b0;
`endif

  logic mem_op, mem_go;
  assign mem_op = ex_mem_valid & (mem_read | mem_write);
  assign mem_go = mem_op & ~misaligned;   // op that actually goes to RAM

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        berr_q, berr_d;
  logic        wb_valid_q, wb_valid_d;
  logic        wb_reg_write_q, wb_reg_write_d;
  logic [4:0]  wb_reg_dest_q, wb_reg_dest_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [31:0] wb_instr_q, wb_instr_d;

  logic timeout;
  assign timeout = (state_q == ACCESS) & ~ram.ram_ack & (cnt_q == TIMEOUT_LAST);

  // MEM/WB bundle as it would be formed from the current EX/MEM contents.
  // Load data is whatever the RAM presents; it only matters with ram_ack.
  logic        bnd_reg_write;
  logic [4:0]  bnd_reg_dest;
  logic [31:0] bnd_data;
  assign bnd_reg_write = reg_write | jal;
  assign bnd_reg_dest  = jal ? RA_REG : ex_mem_reg_dest;
  assign bnd_data      = jal ? ex_mem_pc
                             : (mem_to_reg ? ram.ram_rdata : ex_mem_alu_result);

  // Stall is forced low while reset is asserted so upstream is not frozen by
  // an access that has just been discarded.
  assign stall = reset & (((state_q == IDLE) & mem_go) |
                          ((state_q == ACCESS) & ~ram.ram_ack & ~timeout));

  always_comb begin
    // NOTE: every variable gets a default before the case so no latch is inferred.
    state_d        = state_q;
    cnt_d          = cnt_q;
    req_d          = req_q;
    we_d           = we_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    berr_d         = 1'b0;
    wb_valid_d     = 1'b0;
    wb_reg_write_d = 1'b0;
    wb_reg_dest_d  = wb_reg_dest_q;
    wb_data_d      = wb_data_q;
    wb_instr_d     = wb_instr_q;

    case (state_q)
      IDLE: begin
        if (mem_go) begin
          // Launch the access; WB sees a bubble until it completes.
          req_d   = 1'b1;
          we_d    = mem_write;   // MemRead+MemWrite together is a write
          addr_d  = ex_mem_alu_result;
          wdata_d = ex_mem_write_data;
          cnt_d   = 8'd0;
          state_d = ACCESS;
        end else begin
          wb_valid_d     = ex_mem_valid;
          wb_reg_write_d = bnd_reg_write & ~(mem_op & misaligned);
          wb_reg_dest_d  = bnd_reg_dest;
          wb_data_d      = bnd_data;
          wb_instr_d     = ex_mem_instruction;
        end
      end

      ACCESS: begin
        if (ram.ram_ack || timeout) begin
          // Ack takes priority over a timeout landing in the same cycle.
          req_d          = 1'b0;
          we_d           = 1'b0;
          berr_d         = ~ram.ram_ack;
          wb_valid_d     = ex_mem_valid;
          wb_reg_write_d = bnd_reg_write & ram.ram_ack;
          wb_reg_dest_d  = bnd_reg_dest;
          wb_data_d      = bnd_data;
          wb_instr_d     = ex_mem_instruction;
          state_d        = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      cnt_q          <= 8'd0;
      req_q          <= 1'b0;
      we_q           <= 1'b0;
      addr_q         <= 32'd0;
      wdata_q        <= 32'd0;
      berr_q         <= 1'b0;
      wb_valid_q     <= 1'b0;
      wb_reg_write_q <= 1'b0;
      wb_reg_dest_q  <= 5'd0;
      wb_data_q      <= 32'd0;
      wb_instr_q     <= 32'd0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge next-state.
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      req_q          <= req_d;
      we_q           <= we_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      berr_q         <= berr_d;
      wb_valid_q     <= wb_valid_d;
      wb_reg_write_q <= wb_reg_write_d;
      wb_reg_dest_q  <= wb_reg_dest_d;
      wb_data_q      <= wb_data_d;
      wb_instr_q     <= wb_instr_d;
    end
  end

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  logic misalign_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) misalign_q <= 1'b0;
    else        misalign_q <= (state_q == IDLE) & mem_op & misaligned;
  end
  assign misalign_exc = misalign_q;
`endif

  assign ram.ram_req   = req_q;
  assign ram.ram_we    = we_q;
  assign ram.ram_addr  = addr_q;
  assign ram.ram_wdata = wdata_q;

  assign bus_error      = berr_q;
  assign wb_valid       = wb_valid_q;
  assign wb_reg_write   = wb_reg_write_q;
  assign wb_reg_dest    = wb_reg_dest_q;
  assign wb_data        = wb_data_q;
  assign wb_instruction = wb_instr_q;

endmodule

// File: tb/tb_mem_stage_access.sv
// -----------------------------------------------------------------------------
// tb_mem_stage_access
//   Scoreboard bench for mem_stage_access. Expected MEM/WB bundles are queued
//   when an instruction is driven and compared when wb_valid is observed.
//   RAM bus, stall and bus_error are checked cycle by cycle during accesses.
// -----------------------------------------------------------------------------
module tb_mem_stage_access;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_mem_valid;
  logic [4:0]  ex_mem_reg_dest;
  logic [31:0] ex_mem_write_data;
  logic [31:0] ex_mem_alu_result;
  logic [31:0] ex_mem_instruction;
  logic [31:0] ex_mem_pc;
  logic [4:0]  ex_mem_ctrl;
  logic        stall;
  logic        bus_error;
  logic        wb_valid;
  logic        wb_reg_write;
  logic [4:0]  wb_reg_dest;
  logic [31:0] wb_data;
  logic [31:0] wb_instruction;

  mem_stage_access_if ram_if ();

  mem_stage_access #(.TIMEOUT_CYCLES(TO), .RA_REG(5'd31)) dut (
    .clk                (clk),
    .reset              (reset),
    .ex_mem_valid       (ex_mem_valid),
    .ex_mem_reg_dest    (ex_mem_reg_dest),
    .ex_mem_write_data  (ex_mem_write_data),
    .ex_mem_alu_result  (ex_mem_alu_result),
    .ex_mem_instruction (ex_mem_instruction),
    .ex_mem_pc          (ex_mem_pc),
    .ex_mem_ctrl        (ex_mem_ctrl),
    .ram                (ram_if.master),
    .stall              (stall),
    .bus_error          (bus_error),
    .wb_valid           (wb_valid),
    .wb_reg_write       (wb_reg_write),
    .wb_reg_dest        (wb_reg_dest),
    .wb_data            (wb_data),
    .wb_instruction     (wb_instruction)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        reg_write;
    logic [4:0]  dest;
    logic [31:0] data;
    logic [31:0] instr;
    bit          chk_data;
  } wb_exp_t;

  wb_exp_t sb[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Reference bundle for one instruction.
  function automatic wb_exp_t model(input logic [4:0] ctrl, dest, input logic [31:0] alu,
                                    pc, instr, rdata, input bit timed_out);
    wb_exp_t e;
    e.reg_write = (ctrl[2] | ctrl[4]) & !timed_out;
    e.dest      = ctrl[4] ? 5'd31 : dest;
    e.data      = ctrl[4] ? pc : (ctrl[3] ? rdata : alu);
    e.instr     = instr;
    e.chk_data  = !timed_out;
    return e;
  endfunction

  // Scoreboard consumer.
  always @(negedge clk) begin
    if (wb_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("wb_unexpected", 32'(wb_valid), 32'd0);
      end else begin
        wb_exp_t e;
        e = sb.pop_front();
        check("wb_reg_write", 32'(wb_reg_write), 32'(e.reg_write));
        check("wb_reg_dest", 32'(wb_reg_dest), 32'(e.dest));
        if (e.chk_data) check("wb_data", wb_data, e.data);
        check("wb_instr", wb_instruction, e.instr);
      end
    end
  end

  task automatic drive(input logic v, input logic [4:0] ctrl, dest,
                       input logic [31:0] alu, wdata, pc, instr);
    ex_mem_valid       = v;
    ex_mem_ctrl        = ctrl;
    ex_mem_reg_dest    = dest;
    ex_mem_alu_result  = alu;
    ex_mem_write_data  = wdata;
    ex_mem_pc          = pc;
    ex_mem_instruction = instr;
  endtask

  // Non-memory instruction: one IDLE cycle, never stalls. Optionally asserts
  // ram_ack in IDLE, which must be ignored.
  task automatic alu_op(input logic v, input logic [4:0] ctrl, dest,
                        input logic [31:0] alu, pc, instr, input logic ack_idle);
    drive(v, ctrl, dest, alu, 32'h0, pc, instr);
    ram_if.ram_ack   = ack_idle;
    ram_if.ram_rdata = 32'h0;
    if (v) sb.push_back(model(ctrl, dest, alu, pc, instr, 32'h0, 1'b0));
    @(negedge clk);
    check("alu_stall", 32'(stall), 32'd0);
    check("alu_req", 32'(ram_if.ram_req), 32'd0);
    @(posedge clk); #1;
    ram_if.ram_ack = 1'b0;
    check("alu_req_after", 32'(ram_if.ram_req), 32'd0);
  endtask

  // Memory instruction; ack_at = ACCESS cycle (1..TO) that carries ram_ack,
  // 0 = never acknowledged (timeout).
  task automatic mem_op(input logic [4:0] ctrl, dest, input logic [31:0] addr, wdata,
                        pc, instr, input int ack_at, input logic [31:0] rdata);
    int stall_cnt;
    int req_cnt;
    bit done;
    bit to;
    drive(1'b1, ctrl, dest, addr, wdata, pc, instr);
    sb.push_back(model(ctrl, dest, addr, pc, instr, rdata, ack_at == 0));
    @(negedge clk);
    check("idle_stall", 32'(stall), 32'd1);
    check("idle_req", 32'(ram_if.ram_req), 32'd0);
    stall_cnt = (stall === 1'b1) ? 1 : 0;
    req_cnt   = 0;
    done      = 1'b0;
    to        = 1'b0;
    @(posedge clk); #1;
    for (int i = 1; i <= TO && !done; i++) begin
      if (i == ack_at) begin
        ram_if.ram_ack   = 1'b1;
        ram_if.ram_rdata = rdata;
      end
      @(negedge clk);
      to = (ack_at != i) && (i == TO);
      if (ram_if.ram_req === 1'b1) req_cnt++;
      if (stall === 1'b1) stall_cnt++;
      check("acc_addr", ram_if.ram_addr, addr);
      check("acc_we", 32'(ram_if.ram_we), 32'(ctrl[1]));
      check("acc_wdata", ram_if.ram_wdata, wdata);
      check("acc_stall", 32'(stall), 32'((i != ack_at) && !to));
      @(posedge clk); #1;
      ram_if.ram_ack = 1'b0;
      done = (i == ack_at) || to;
    end
    ex_mem_valid = 1'b0;
    @(negedge clk);
    check("post_req", 32'(ram_if.ram_req), 32'd0);
    check("bus_error", 32'(bus_error), 32'(to));
    @(posedge clk); #1;
    @(negedge clk);
    check("bus_error_pulse", 32'(bus_error), 32'd0);
    check("stall_cycles", 32'(stall_cnt), 32'((ack_at == 0) ? TO : ack_at));
    check("req_cycles", 32'(req_cnt), 32'((ack_at == 0) ? TO : ack_at));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    ram_if.ram_ack   = 1'b0;
    ram_if.ram_rdata = 32'h0;
    #2;
    check("rst_req", 32'(ram_if.ram_req), 32'd0);
    check("rst_we", 32'(ram_if.ram_we), 32'd0);
    check("rst_addr", ram_if.ram_addr, 32'd0);
    check("rst_wdata", ram_if.ram_wdata, 32'd0);
    check("rst_berr", 32'(bus_error), 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_wb_rw", 32'(wb_reg_write), 32'd0);
    check("rst_wb_dest", 32'(wb_reg_dest), 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_wb_instr", wb_instruction, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Directed cases
    alu_op(1'b1, 5'b00100, 5'd5, 32'h0000_1234, 32'h0040_0004, 32'h0123_0001, 1'b0);
    mem_op(5'b01101, 5'd8, 32'h0000_0040, 32'h0, 32'h0040_0008, 32'h8C08_0040, 3, 32'hDEAD_BEEF);
    mem_op(5'b00010, 5'd0, 32'h0000_0080, 32'hCAFE_F00D, 32'h0040_000C, 32'hAC09_0080, 2, 32'h0);
    alu_op(1'b1, 5'b10000, 5'd0, 32'h0000_0000, 32'h0040_0010, 32'h0C10_0004, 1'b0);
    mem_op(5'b01101, 5'd9, 32'h0000_0100, 32'h0, 32'h0040_0014, 32'h8C09_0100, 0, 32'h0);
    mem_op(5'b01101, 5'd10, 32'h0000_0104, 32'h0, 32'h0040_0018, 32'h8C0A_0104, TO, 32'h1357_9BDF);
    alu_op(1'b1, 5'b00100, 5'd11, 32'h0000_5555, 32'h0040_001C, 32'h0123_0002, 1'b1);
    mem_op(5'b00011, 5'd0, 32'h0000_0200, 32'hA5A5_5A5A, 32'h0040_0020, 32'hAC0B_0200, 1, 32'h0);
    alu_op(1'b0, 5'b01101, 5'd12, 32'h0000_0300, 32'h0040_0024, 32'h8C0C_0300, 1'b0);
    mem_op(5'b01101, 5'd13, 32'h0000_0044, 32'h0, 32'h0040_0028, 32'h8C0D_0044, 1, 32'h0BAD_F00D);

    // Reset in the middle of an access
    drive(1'b1, 5'b01101, 5'd14, 32'h0000_0400, 32'h0, 32'h0040_002C, 32'h8C0E_0400);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst_req", 32'(ram_if.ram_req), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_req", 32'(ram_if.ram_req), 32'd0);
    check("mid_rst_stall", 32'(stall), 32'd0);
    check("mid_rst_wb_valid", 32'(wb_valid), 32'd0);
    ex_mem_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    mem_op(5'b01101, 5'd15, 32'h0000_0408, 32'h0, 32'h0040_0030, 32'h8C0F_0408, 2, 32'h2468_ACE0);

    // Random mix
    for (int n = 0; n < 10; n++) begin
      int kind;
      logic [31:0] a;
      kind = int'($urandom_range(0, 3));
      a    = $urandom() & 32'hFFFF_FFFC;
      case (kind)
        0: alu_op(1'b1, 5'b00100, 5'($urandom_range(1, 30)), $urandom(), $urandom(), $urandom(), 1'b0);
        1: alu_op(1'b1, 5'b10000, 5'($urandom_range(1, 30)), $urandom(), $urandom(), $urandom(), 1'b0);
        2: mem_op(5'b01101, 5'($urandom_range(1, 30)), a, 32'h0, $urandom(), $urandom(),
                  int'($urandom_range(0, TO)), $urandom());
        default: mem_op(5'b00010, 5'($urandom_range(1, 30)), a, $urandom(), $urandom(), $urandom(),
                        int'($urandom_range(0, TO)), 32'h0);
      endcase
    end

    drive(1'b0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
